thor2023_icache_req_generator: RTL and testbench
================================================

# thor2023_icache_req_generator

Instruction-cache miss request initiator: turns a cache miss into two 128-bit Wishbone burst-less read requests, one per half of a 256-bit line. It is the request-side counterpart of the icache ack processor. It allocates one of eight transaction slots per line and encodes that slot in the request tid. It publishes the per-tid virtual tag table consumed by the ack processor, and retires slots when completed lines are written to the cache.

## Interface
Parameters:
- CHANNEL, 4'h0, value driven on tid[7:4] of every request.
- SEL, 16'hFFFF, byte select driven on every request.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- miss  input  1  level; cache miss pending, held until miss_ack.
- miss_vadr  input  address_t  virtual address of missing fetch.
- miss_padr  input  address_t  physical address of missing fetch.
- miss_ack  output  1  one-cycle pulse: miss accepted (issued or dropped as duplicate).
- wbm_req  output  wb_cmd_request128_t  request; drives cyc, stb, we=0, sel=SEL, adr, tid; other fields 0.
- wbm_rdy  input  1  downstream accepts wbm_req in any cycle with stb & wbm_rdy.
- line_done  input  1  ack processor wrote a line to cache (its wr_ic).
- line_ptag  input  address_t  ptag of that line (its line_o.ptag).
- vtags  output  address_t [15:0]  virtual tag per tid[3:0].
- full  output  1  all eight slots busy.
- pending  output  4  number of busy slots, 0..8.

## Operation
- Slot state: busy[7:0], slot_padr[7:0] (line address, miss_padr & ~'h1F).
- tid encoding: tid = {CHANNEL, slot[2:0], half}, half = 0 for low 128 bits, 1 for high.
- Request address: (miss_padr & ~'h1F) | (half << 4).
- FSM states IDLE, REQ0, REQ1:
  - IDLE: if miss is high, compare miss_padr & ~'h1F against slot_padr of every busy slot.
    - Match (duplicate): pulse miss_ack; no request; stay IDLE.
    - No match, free slot exists: allocate the lowest-indexed free slot; set busy; latch line address; write vtags[{slot,0}] = vadr & ~'h1F and vtags[{slot,1}] = (vadr & ~'h1F) | 'h10; pulse miss_ack; go to REQ0.
    - No match, full: wait in IDLE, no miss_ack.
  - REQ0: cyc=stb=1, adr low half, tid half=0. If wbm_rdy, go to REQ1.
  - REQ1: cyc=stb=1, adr high half, tid half=1. If wbm_rdy, go to IDLE with cyc=stb=0.
- Retire: when line_done is high, clear busy of every slot whose slot_padr equals line_ptag & ~'h1F. A line_done with no match is ignored.
- Simultaneous retire and allocate: allocation and the duplicate check use the busy vector from before the clear. A freed slot is allocatable the next cycle. A miss matching the line being retired in the same cycle is dropped as a duplicate.
- pending = popcount(busy); full = (busy == 8'hFF). Both are registered from next-state busy.
- vtags entries hold their value until overwritten by a later allocation of the same slot.

## Timing
- All outputs are registered.
- Reset values: wbm_req all zero, miss_ack 0, vtags all 0, busy 0, slot_padr 0, full 0, pending 0, state IDLE.
- Reset asserted mid-request drops cyc/stb immediately (asynchronous) and discards all slots.
- Miss sampled in IDLE at edge T:
  - miss_ack high in cycle T+1.
  - vtags valid and first request on the bus in T+1.
- With wbm_rdy constantly high:
  - REQ0 in T+1, REQ1 in T+2, IDLE in T+3.
  - Earliest next miss sample at T+3, so 3 cycles per line.
- wbm_rdy low holds adr, tid and stb stable.
- Duplicate drop: miss_ack is high in T+1 and the FSM stays IDLE.
- line_done sampled at edge T: busy clear, pending and full update in T+1.

## Test plan
- Single miss: vadr 'h1000_0040, padr 'h0200_0048, rdy=1. Expect miss_ack at T+1; requests adr 'h0200_0040 tid 'h00, then adr 'h0200_0050 tid 'h01. Expect vtags[0]='h1000_0040, vtags[1]='h1000_0050, pending=1.
- Back-pressure: wbm_rdy low for 5 cycles in REQ0. Expect adr, tid and stb stable; REQ1 one cycle after rdy rises.
- Fill and full: 8 distinct misses. Expect slots 0..7 (tids 'h00..'h0F), full=1, pending=8. A 9th miss gets no miss_ack until line_done for slot 3's ptag; it then allocates slot 3 (tid 'h06).
- Duplicate: miss to a line already busy, e.g. padr 'h0200_0058 after the single-miss case. Expect miss_ack, no cyc, pending unchanged.
- Simultaneous: full, line_done for slot 5 and a new miss in the same cycle. Expect no allocation that cycle; slot 5 allocated the next cycle.
- Async reset during REQ1: expect cyc=stb=0 immediately, pending=0, vtags all 0.

Source files
------------

// File: rtl/thor2023_icache_req_generator.sv
// Icache miss -> two 128-bit Wishbone reads per 256-bit line, tracked in one of eight tid slots.
// Ack/request in the cycle after the miss is sampled; wbm_rdy low freezes the request; full holds off misses.
package thor2023_icache_pkg;
  typedef logic [31:0] address_t;

  typedef struct packed {
    logic           cyc;
    logic           stb;
    logic           we;
    logic [15:0]    sel;
    logic [7:0]     tid;
    address_t       adr;
    logic [127:0]   dat;
  } wb_cmd_request128_t;
endpackage

module thor2023_icache_req_generator
  import thor2023_icache_pkg::*;
#(
  parameter logic [3:0]  CHANNEL = 4'h0,
  parameter logic [15:0] SEL     = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               miss,
  input  address_t           miss_vadr,
  input  address_t           miss_padr,
  output logic               miss_ack,
  output wb_cmd_request128_t wbm_req,
  input  logic               wbm_rdy,
  input  logic               line_done,
  input  address_t           line_ptag,
  output address_t [15:0]    vtags,
  output logic               full,
  output logic [3:0]         pending
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ0 = 2'd1;
  localparam logic [1:0] REQ1 = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [7:0]         busy_q, busy_d;
  address_t [7:0]     slot_padr_q;
  address_t [15:0]    vtags_q;
  wb_cmd_request128_t req_q, req_d;
  logic               miss_ack_q, miss_ack_d;
  logic               full_q;
  logic [3:0]         pending_q, pending_d;

  address_t   miss_line, ptag_line, vadr_line;
  logic [7:0] hit_vec, retire_vec;
  logic       free_vld;
  logic [2:0] free_idx;
  logic       accept, dup, alloc;

  assign miss_line = miss_padr & ~32'h1F;
  assign ptag_line = line_ptag & ~32'h1F;
  assign vadr_line = miss_vadr & ~32'h1F;

  always_comb begin
    hit_vec    = '0;
    retire_vec = '0;
    free_vld   = 1'b0;
    free_idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      hit_vec[i]    = busy_q[i] && (slot_padr_q[i] == miss_line);
      retire_vec[i] = line_done && (slot_padr_q[i] == ptag_line);
    end
    for (int i = 7; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_vld = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  // The miss is still held during its ack cycle, so that cycle is not a new sample.
  assign accept = (state_q == IDLE) && miss && !miss_ack_q;
  assign dup    = accept && (|hit_vec);
  assign alloc  = accept && !(|hit_vec) && free_vld;

  always_comb begin
    busy_d = busy_q & ~retire_vec;
    if (alloc) busy_d[free_idx] = 1'b1;
    pending_d = '0;
    for (int i = 0; i < 8; i++) pending_d = pending_d + 4'(busy_d[i]);
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    miss_ack_d = dup | alloc;
    case (state_q)
      IDLE: begin
        if (alloc) begin
          state_d   = REQ0;
          req_d     = '0;
          req_d.cyc = 1'b1;
          req_d.stb = 1'b1;
          req_d.sel = SEL;
          req_d.adr = miss_line;
          req_d.tid = {CHANNEL, free_idx, 1'b0};
        end
      end
      REQ0: begin
        if (wbm_rdy) begin
          state_d    = REQ1;
          req_d.adr  = req_q.adr | 32'h10;
          req_d.tid  = {req_q.tid[7:1], 1'b1};
        end
      end
      REQ1: begin
        if (wbm_rdy) begin
          state_d = IDLE;
          req_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= '0;
      slot_padr_q <= '0;
      vtags_q     <= '0;
      req_q       <= '0;
      miss_ack_q  <= 1'b0;
      full_q      <= 1'b0;
      pending_q   <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      miss_ack_q <= miss_ack_d;
      full_q     <= (busy_d == 8'hFF);
      pending_q  <= pending_d;
      if (alloc) begin
        slot_padr_q[free_idx]       <= miss_line;
        vtags_q[{free_idx, 1'b0}]   <= vadr_line;
        vtags_q[{free_idx, 1'b1}]   <= vadr_line | 32'h10;
      end
    end
  end

  assign miss_ack = miss_ack_q;
  assign wbm_req  = req_q;
  assign vtags    = vtags_q;
  assign full     = full_q;
  assign pending  = pending_q;

endmodule

// File: tb/tb_thor2023_icache_req_generator.sv
// Scoreboard bench for the icache request generator: expected bus requests are queued when misses are driven.
module tb_thor2023_icache_req_generator;
  import thor2023_icache_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               miss = 1'b0;
  address_t           miss_vadr = '0;
  address_t           miss_padr = '0;
  logic               miss_ack;
  wb_cmd_request128_t wbm_req;
  logic               wbm_rdy = 1'b1;
  logic               line_done = 1'b0;
  address_t           line_ptag = '0;
  address_t [15:0]    vtags;
  logic               full;
  logic [3:0]         pending;

  thor2023_icache_req_generator #(.CHANNEL(4'h0), .SEL(16'hFFFF)) dut (
    .clk(clk), .rst_n(rst_n), .miss(miss), .miss_vadr(miss_vadr), .miss_padr(miss_padr),
    .miss_ack(miss_ack), .wbm_req(wbm_req), .wbm_rdy(wbm_rdy), .line_done(line_done),
    .line_ptag(line_ptag), .vtags(vtags), .full(full), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    address_t   adr;
    logic [7:0] tid;
  } exp_t;

  exp_t     sb[$];
  logic [7:0] m_busy = '0;
  address_t m_padr[8];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every accepted bus beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && wbm_req.cyc && wbm_req.stb && wbm_rdy) begin
      if (sb.size() == 0) begin
        chk("req_queue_nonempty", 64'(sb.size()), 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("req_adr", 64'(wbm_req.adr), 64'(e.adr));
        chk("req_tid", 64'(wbm_req.tid), 64'(e.tid));
        chk("req_we_sel", 64'({wbm_req.we, wbm_req.sel}), 64'({1'b0, 16'hFFFF}));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_slot(input int s, input address_t ln);
    exp_t e;
    m_busy[s] = 1'b1;
    m_padr[s] = ln;
    e.adr = ln;
    e.tid = {4'h0, 3'(s), 1'b0};
    sb.push_back(e);
    e.adr = ln | 32'h10;
    e.tid = {4'h0, 3'(s), 1'b1};
    sb.push_back(e);
  endtask

  task automatic wait_ack(output int lat);
    logic got;
    got = 1'b0;
    lat = 0;
    @(posedge clk);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (miss_ack) got = 1'b1;
    end
    chk("ack_seen", 64'(got), 64'd1);
  endtask

  task automatic issue(input address_t va, input address_t pa, output int lat);
    address_t ln;
    logic d;
    int s;
    ln = pa & ~32'h1F;
    d = 1'b0;
    s = -1;
    for (int i = 0; i < 8; i++) if (m_busy[i] && m_padr[i] == ln) d = 1'b1;
    if (!d) for (int i = 7; i >= 0; i--) if (!m_busy[i]) s = i;
    if (!d && s >= 0) push_slot(s, ln);
    miss_vadr = va;
    miss_padr = pa;
    miss = 1'b1;
    wait_ack(lat);
    step();
    miss = 1'b0;
  endtask

  initial begin
    int lat;
    address_t cap_adr;
    logic [7:0] cap_tid;
    for (int i = 0; i < 8; i++) m_padr[i] = '0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cyc", 64'(wbm_req.cyc), 64'd0);
    chk("rst_ack", 64'(miss_ack), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_vtag0", 64'(vtags[0]), 64'd0);
    step();

    // Single miss: slot 0.
    issue(32'h1000_0040, 32'h0200_0048, lat);
    chk("single_ack_lat", 64'(lat), 64'd1);
    @(negedge clk);
    chk("single_vtag0", 64'(vtags[0]), 64'h1000_0040);
    chk("single_vtag1", 64'(vtags[1]), 64'h1000_0050);
    chk("single_pending", 64'(pending), 64'd1);
    step();

    // Duplicate of the busy line.
    issue(32'h1000_0058, 32'h0200_0058, lat);
    chk("dup_ack_lat", 64'(lat), 64'd1);
    @(negedge clk);
    chk("dup_no_cyc", 64'(wbm_req.cyc), 64'd0);
    chk("dup_pending", 64'(pending), 64'd1);
    step();

    // Back-pressure in REQ0: slot 1.
    wbm_rdy = 1'b0;
    issue(32'h1000_0100, 32'h0200_0100, lat);
    cap_adr = wbm_req.adr;
    cap_tid = wbm_req.tid;
    chk("bp_first_adr", 64'(cap_adr), 64'h0200_0100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_adr_stable", 64'(wbm_req.adr), 64'(cap_adr));
      chk("bp_tid_stable", 64'(wbm_req.tid), 64'(cap_tid));
      chk("bp_stb_stable", 64'(wbm_req.stb), 64'd1);
    end
    step();
    wbm_rdy = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_req1_tid", 64'(wbm_req.tid), 64'h03);
    chk("bp_req1_adr", 64'(wbm_req.adr), 64'h0200_0110);
    step();

    // Fill slots 2..7.
    for (int i = 2; i < 8; i++) begin
      issue(32'h2000_0000 + 32'(i << 8), 32'h0300_0000 + 32'(i << 8), lat);
    end
    @(negedge clk);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_pending", 64'(pending), 64'd8);
    chk("fill_vtag15", 64'(vtags[15]), 64'h2000_0710);
    step();
    step();

    // Ninth miss waits until slot 3 retires.
    miss_vadr = 32'h3000_0000;
    miss_padr = 32'h0400_0000;
    miss = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("full_no_ack", 64'(miss_ack), 64'd0);
    end
    step();
    line_done = 1'b1;
    line_ptag = m_padr[3] | 32'h7;
    m_busy[3] = 1'b0;
    push_slot(3, 32'h0400_0000);
    step();
    line_done = 1'b0;
    @(negedge clk);
    chk("retire_pending", 64'(pending), 64'd7);
    chk("retire_not_yet_ack", 64'(miss_ack), 64'd0);
    wait_ack(lat);
    chk("ninth_ack_lat", 64'(lat), 64'd1);
    chk("ninth_vtag6", 64'(vtags[6]), 64'h3000_0000);
    step();
    miss = 1'b0;
    @(negedge clk);
    chk("ninth_pending", 64'(pending), 64'd8);
    step();
    step();
    step();

    // Simultaneous retire of slot 5 and a new miss.
    line_done = 1'b1;
    line_ptag = m_padr[5];
    m_busy[5] = 1'b0;
    push_slot(5, 32'h0500_0000);
    miss_vadr = 32'h4000_0000;
    miss_padr = 32'h0500_0000;
    miss = 1'b1;
    step();
    line_done = 1'b0;
    @(negedge clk);
    chk("simul_no_ack", 64'(miss_ack), 64'd0);
    chk("simul_pending", 64'(pending), 64'd7);
    chk("simul_full", 64'(full), 64'd0);
    wait_ack(lat);
    chk("simul_ack_lat", 64'(lat), 64'd1);
    chk("simul_vtag11", 64'(vtags[11]), 64'h4000_0010);
    step();
    miss = 1'b0;
    step();
    step();

    // Async reset while REQ1 is stalled.
    line_done = 1'b1;
    line_ptag = m_padr[0];
    m_busy[0] = 1'b0;
    step();
    line_done = 1'b0;
    wbm_rdy = 1'b0;
    issue(32'h5000_0000, 32'h0600_0000, lat);
    wbm_rdy = 1'b1;
    @(negedge clk);
    step();
    wbm_rdy = 1'b0;
    @(negedge clk);
    chk("pre_rst_tid", 64'(wbm_req.tid), 64'h01);
    chk("pre_rst_cyc", 64'(wbm_req.cyc), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 64'(wbm_req.cyc), 64'd0);
    chk("arst_stb", 64'(wbm_req.stb), 64'd0);
    chk("arst_pending", 64'(pending), 64'd0);
    chk("arst_full", 64'(full), 64'd0);
    for (int i = 0; i < 16; i++) chk("arst_vtag", 64'(vtags[i]), 64'd0);
    chk("arst_sb_left", 64'(sb.size()), 64'd1);
    sb.delete();
    m_busy = '0;
    step();
    rst_n = 1'b1;
    wbm_rdy = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
